load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Memory-stage load/store engine between the ALU result and the data-memory bus.
//   Aligns and byte-enables stores. Fetches and sign- or zero-extends loads.
//   Stalls the pipeline until the bus acks or a timeout expires.
//   load_data drives the 'memory' input of the write-back select mux.
// PARAMETERS
//   TIMEOUT   255   max cycles in BUSY waiting for dmem_ack before faulting (1..255)
// PORTS
//   clk          in   1   pipeline clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   mem_op       in   2   0=none 1=load 2=store 3=none(reserved)
//   size         in   2   0=byte 1=half 2=word 3=treated as word
//   unsigned_ld  in   1   1=zero-extend loads, 0=sign-extend
//   addr         in   32  byte address (ALU result)
//   wdata        in   32  store data (rs2)
//   stall        out  1   hold pipeline while a memory op is unfinished
//   done         out  1   one-cycle pulse: op finished (with or without fault)
//   fault        out  1   one-cycle pulse with done: misaligned or timeout
//   load_data    out  32  extended load result, to write-back mux
//   dmem_req     out  1   bus request
//   dmem_we      out  1   1=write
//   dmem_addr    out  32  word address {addr[31:2],2'b00}
//   dmem_be      out  4   byte enables, bit i = byte lane i (bits 8i+7:8i)
//   dmem_wdata   out  32  lane-replicated store data
//   dmem_ack     in   1   bus completion; rdata valid same cycle for loads
//   dmem_rdata   in   32  bus read data
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; all outputs 0, including load_data and timer.
//     An in-flight bus request is dropped immediately; no completion is reported.
//   FSM states: IDLE, BUSY, DONE.
//   IDLE:
//     mem_op in {1,2}, aligned -> latch op/size/unsigned/addr/wdata; next state BUSY.
//     mem_op in {1,2}, misaligned -> next state DONE with fault; no bus access.
//       Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//     stall = (mem_op==1 || mem_op==2), combinational.
//     dmem_ack is ignored in IDLE.
//   BUSY:
//     dmem_req=1, stall=1; dmem_we/addr/be/wdata driven from latched values.
//     All bus signals stay stable until ack.
//     On dmem_ack: loads capture the extended rdata into load_data. Next state DONE.
//     Timer counts up from 0 on BUSY entry. If timer reaches TIMEOUT-1 with no ack:
//       drop req; next state DONE with fault.
//     ack and timeout in the same cycle -> ack wins, no fault.
//   DONE: done=1, fault per cause, stall=0, dmem_req=0. Always returns to IDLE.
//     mem_op is ignored here: it still belongs to the op just completed.
//   Byte lane: lane=addr[1:0] for bytes; addr[1]*2 for halves.
//   Store be: byte 4'b0001<<lane; half 4'b0011 or 4'b1100; word 4'b1111.
//   Store wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//   Load extract: byte rdata[8*lane+:8]; half rdata[16*addr[1]+:16]; word rdata.
//     Extended to 32 bits per unsigned_ld (ignored for word).
//   load_data holds its value until the next successful load.
//     Stores, faults and timeouts leave it unchanged.
//   Minimum latency with ack in the first BUSY cycle: issue in IDLE, ack in BUSY,
//     done in DONE = 3 cycles, stall high for 2.
// TESTING
//   1. Load byte, addr=0x1003, unsigned_ld=0, rdata=0x80FF_0000 on first BUSY cycle:
//      dmem_addr=0x1000, be=4'b1000, load_data=0xFFFF_FF80, done 1 cycle later.
//   2. Store half, addr=0x2002, wdata=0x1234_ABCD:
//      be=4'b1100, dmem_wdata=0xABCD_ABCD, we=1, ack after 5 cycles;
//      stall high for 6 cycles, load_data unchanged.
//   3. Load word, addr=0x0006:
//      fault+done in next cycle, dmem_req never asserted.
//   4. Load, ack never arrives, TIMEOUT=8:
//      req high for 8 cycles, then done+fault; ack in the same cycle as the
//      timeout limit -> no fault, data captured.
//   5. rst_n pulsed low mid-BUSY:
//      req/stall drop asynchronously, no done; a load issued after reset completes normally.
//   6. Back-to-back loads (lhu 0x10 then lb 0x11), zero-wait ack:
//      second op issues the cycle after the first op's DONE; load_data 0x0000_BEEF then
//      the second op's sign-extended byte.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store engine with byte lanes, extension and ack timeout
// Three-state FSM (IDLE/BUSY/DONE); bus signals are only driven while BUSY.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mem_op,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  timer_q, timer_d;
    logic        fault_q, fault_d;
    logic [31:0] load_data_q, load_data_d;

    logic        op_valid;
    logic        misaligned;
    logic [1:0]  lane;
    logic [31:0] rdata_shifted;
    logic [31:0] rdata_ext;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    assign op_valid   = (mem_op == 2'd1) || (mem_op == 2'd2);
    assign misaligned = ((size == 2'd1) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));

    // Lane decode works on latched values so the bus stays stable through BUSY.
    assign lane          = (size_q == 2'd0) ? addr_q[1:0] : {addr_q[1], 1'b0};
    assign rdata_shifted = dmem_rdata >> {lane, 3'b000};

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
        rdata_ext = dmem_rdata;
        case (size_q)
            2'd0: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata_q[7:0]}};
                rdata_ext = {{24{~uns_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            end
            2'd1: begin
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
                rdata_ext = {{16{~uns_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
                rdata_ext = dmem_rdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        timer_d     = timer_q;
        fault_d     = fault_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                fault_d = 1'b0;
                timer_d = 8'd0;
                if (op_valid) begin
                    if (misaligned) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        we_d    = (mem_op == 2'd2);
                        size_d  = size;
                        uns_d   = unsigned_ld;
                        addr_d  = addr;
                        wdata_d = wdata;
                    end
                end
            end
            S_BUSY: begin
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (dmem_ack) begin
                    state_d = S_DONE;
                    fault_d = 1'b0;
                    if (!we_q) begin
                        load_data_d = rdata_ext;
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            timer_q     <= 8'd0;
            fault_q     <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            timer_q     <= timer_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
        end
    end

    // Stall is gated by rst_n so it falls with the reset even if mem_op is still held.
    assign stall      = rst_n && ((state_q == S_BUSY) || ((state_q == S_IDLE) && op_valid));
    assign done       = (state_q == S_DONE);
    assign fault      = (state_q == S_DONE) && fault_q;
    assign load_data  = load_data_q;
    assign dmem_req   = (state_q == S_BUSY);
    assign dmem_we    = (state_q == S_BUSY) && we_q;
    assign dmem_addr  = (state_q == S_BUSY) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_be    = (state_q == S_BUSY) ? be : 4'b0000;
    assign dmem_wdata = (state_q == S_BUSY && we_q) ? wdata_rep : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural bus/lane model
module tb_load_store_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mem_op;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ld_model = 32'd0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_op(mem_op), .size(size), .unsigned_ld(unsigned_ld),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .fault(fault),
        .load_data(load_data), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned v;
        if (sz == 2'd0) v = 1 << (a % 4);
        else if (sz == 2'd1) v = 3 << (2 * ((a / 2) % 2));
        else v = 15;
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Runs one op end to end; ack_wait = BUSY cycles before ack (>= TMO means never).
    task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_wait, input string tag);
        bit mis, acked, timed;
        int nbusy;
        mis = m_misaligned(sz, a);
        @(negedge clk);
        mem_op = op; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
        dmem_ack = 1'b0; dmem_rdata = rd;
        #1;
        n_cmp++;
        if (stall !== 1'b1 || dmem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL %s issue: stall=%b req=%b want stall=1 req=0", tag, stall, dmem_req);
        end
        acked = 0; timed = 0; nbusy = 0;
        if (!mis) begin
            while (!acked && !timed) begin
                @(negedge clk);
                dmem_ack = (nbusy == ack_wait);
                #1;
                n_cmp++;
                if (dmem_req !== 1'b1 || stall !== 1'b1 || done !== 1'b0 || dmem_we !== (op == 2'd2)
                    || dmem_addr !== (a & 32'hFFFF_FFFC) || dmem_be !== m_be(sz, a)) begin
                    n_bad++;
                    $display("FAIL %s busy%0d: req=%b stall=%b done=%b we=%b addr=%h be=%b want 1 1 0 %b %h %b",
                             tag, nbusy, dmem_req, stall, done, dmem_we, dmem_addr, dmem_be,
                             op == 2'd2, a & 32'hFFFF_FFFC, m_be(sz, a));
                end
                if (op == 2'd2) begin
                    n_cmp++;
                    if (dmem_wdata !== m_wdata(sz, wd)) begin
                        n_bad++;
                        $display("FAIL %s wdata: got %h want %h", tag, dmem_wdata, m_wdata(sz, wd));
                    end
                end
                if (dmem_ack) acked = 1;
                else if (nbusy == TMO - 1) timed = 1;
                nbusy++;
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        if (op == 2'd1 && acked) ld_model = m_load(sz, uns, a, rd);
        n_cmp++;
        if (done !== 1'b1 || fault !== (mis || timed) || stall !== 1'b0 || dmem_req !== 1'b0
            || load_data !== ld_model) begin
            n_bad++;
            $display("FAIL %s done: done=%b fault=%b stall=%b req=%b ld=%h want 1 %b 0 0 %h",
                     tag, done, fault, stall, dmem_req, load_data, mis || timed, ld_model);
        end
        mem_op = 2'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_op = 2'd0; size = 2'd0; unsigned_ld = 1'b0; addr = 32'd0;
        wdata = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({stall, done, fault, dmem_req, dmem_we, dmem_be} !== 9'd0 || load_data !== 32'd0
            || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset outputs: stall=%b done=%b fault=%b req=%b ld=%h want all 0",
                     stall, done, fault, dmem_req, load_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ops;
        @(negedge clk);
        mem_op = 2'd3; dmem_ack = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL idle op3 stall: got %b want 0", stall);
        end
        @(negedge clk);
        mem_op = 2'd0;
        #1;
        n_cmp++;
        if (dmem_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL idle no-op: req=%b done=%b stall=%b want 0 0 0", dmem_req, done, stall);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_directed;
        run_op(2'd1, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, "lb_1003");
        n_cmp++;
        if (load_data !== 32'hFFFF_FF80) begin
            n_bad++;
            $display("FAIL lb_1003 value: got %h want ffffff80", load_data);
        end
        run_op(2'd2, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 4, "sh_2002");
        n_cmp++;
        if (load_data !== 32'hFFFF_FF80) begin
            n_bad++;
            $display("FAIL sh_2002 load_data kept: got %h want ffffff80", load_data);
        end
        run_op(2'd1, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 32'hDEAD_BEEF, 0, "lw_misaligned");
    endtask

    task automatic test_timeout;
        run_op(2'd1, 2'd2, 1'b0, 32'h0000_0040, 32'd0, 32'h1111_2222, 50, "lw_timeout");
        run_op(2'd1, 2'd2, 1'b0, 32'h0000_0044, 32'd0, 32'hCAFE_F00D, TMO - 1, "lw_ack_at_limit");
        n_cmp++;
        if (load_data !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL ack_at_limit value: got %h want cafef00d", load_data);
        end
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clk);
        mem_op = 2'd1; size = 2'd2; addr = 32'h0000_0100; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (dmem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid pre: req=%b want 1", dmem_req);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid async: req=%b stall=%b done=%b want 0 0 0", dmem_req, stall, done);
        end
        mem_op = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        ld_model = 32'd0;
        repeat (2) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0 || dmem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid after: done=%b req=%b want 0 0", done, dmem_req);
            end
        end
        run_op(2'd1, 2'd1, 1'b1, 32'h0000_0102, 32'd0, 32'h8765_4321, 1, "lhu_after_rst");
    endtask

    task automatic test_back_to_back;
        run_op(2'd1, 2'd1, 1'b1, 32'h0000_0010, 32'd0, 32'h1234_BEEF, 0, "b2b_lhu");
        n_cmp++;
        if (load_data !== 32'h0000_BEEF) begin
            n_bad++;
            $display("FAIL b2b first: got %h want 0000beef", load_data);
        end
        run_op(2'd1, 2'd0, 1'b0, 32'h0000_0011, 32'd0, 32'h0000_9A00, 0, "b2b_lb");
        n_cmp++;
        if (load_data !== 32'hFFFF_FF9A) begin
            n_bad++;
            $display("FAIL b2b second: got %h want ffffff9a", load_data);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op, sz;
            logic [31:0] a;
            op = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~32'd1) : (a & ~32'd3);
            run_op(op, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                   $urandom_range(0, TMO + 1), $sformatf("rnd%0d", i));
        end
    endtask

    initial begin
        test_reset;
        test_idle_ops;
        test_directed;
        test_timeout;
        test_reset_mid_busy;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
